// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl
//
// Wraps a free-running FIR pipeline that has no flow control of its own and
// gives it a valid/ready stream on both sides. Each accepted input sample
// becomes a one-cycle FIR enable. A valid bit then follows the sample down a
// shadow pipe of LATENCY stages. When the bit reaches the end of the pipe, the
// FIR output is captured into a show-ahead FIFO.
//
// Admission is credit based: a sample is only accepted if the FIFO has room
// for it, counting every sample still inside the FIR. Downstream backpressure
// therefore stalls the input side and never drops a sample that is already in
// the FIR.
//
// A clear (or reset release) holds the FIR synchronous reset for one cycle.
// It also discards every in-flight and buffered result, and restarts the
// warm-up tracking.
//
// State table (FIR reset sequencer):
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_SRST | FIR i_srst asserted; no samples accepted this cycle
//   ST_RUN  | normal streaming
//
// Ports:
//   clk          clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_s_valid    input sample valid
//   o_s_ready    input sample accepted this cycle
//   i_s_data     input sample
//   i_clear      synchronous clear command (pulse or level)
//   o_fir_en     FIR i_en
//   o_fir_srst   FIR i_srst
//   o_fir_data   FIR i_data (combinational passthrough of i_s_data)
//   i_fir_data   FIR o_data
//   o_m_valid    output sample valid
//   i_m_ready    downstream ready
//   o_m_data     filtered sample
//   o_m_warm     sample produced during the FIR warm-up window
//   o_busy       samples in flight or buffered

module fir_stream_ctrl #(
  parameter int WW_INPUT   = 8,
  parameter int WW_OUTPUT  = 8,
  parameter int LATENCY    = 3,
  parameter int NUM_TAPS   = 15,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_s_valid,
  output logic                 o_s_ready,
  input  logic [WW_INPUT-1:0]  i_s_data,
  input  logic                 i_clear,
  output logic                 o_fir_en,
  output logic                 o_fir_srst,
  output logic [WW_INPUT-1:0]  o_fir_data,
  input  logic [WW_OUTPUT-1:0] i_fir_data,
  output logic                 o_m_valid,
  input  logic                 i_m_ready,
  output logic [WW_OUTPUT-1:0] o_m_data,
  output logic                 o_m_warm,
  output logic                 o_busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ACC_W = (NUM_TAPS > 2) ? $clog2(NUM_TAPS) : 1;

  localparam logic [ACC_W-1:0] WARM_LIMIT = ACC_W'(NUM_TAPS - 1);
  localparam logic [CNT_W:0]   DEPTH_LIM  = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // FIR reset sequencer
  // ---------------------------------------------------------------------------
  typedef enum logic {
    ST_SRST = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   srst_q;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_SRST;
    end else begin
      state_q <= state_d;
    end
  end

  // A clear seen at an edge puts the FIR into reset for the following cycle.
  // The first edge without a clear releases it.
  always_comb begin
    state_d = ST_RUN;
    if (i_clear) begin
      state_d = ST_SRST;
    end
  end

  assign srst_q     = (state_q == ST_SRST);
  assign o_fir_srst = srst_q;

  // ---------------------------------------------------------------------------
  // Handshake and credit admission
  // ---------------------------------------------------------------------------
  logic [LATENCY:1]   vld;
  logic [LATENCY:1]   warm_pipe;
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W:0]     credit_used;
  logic               fire;
  logic               push;
  logic               pop;

  always_comb begin
    inflight = '0;
    for (int i = 1; i <= LATENCY; i++) begin
      inflight = inflight + CNT_W'(vld[i]);
    end
  end

  // Every sample inside the FIR already owns a FIFO slot, so a stalled
  // consumer can never cause a capture into a full FIFO.
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
  assign o_s_ready   = ~i_clear & ~srst_q & (credit_used < DEPTH_LIM);
  assign fire        = i_s_valid & o_s_ready;
  assign o_fir_en    = fire;
  assign o_fir_data  = i_s_data;

  // ---------------------------------------------------------------------------
  // Warm-up counter: saturates once the FIR tap line has been filled
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] acc_cnt;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      acc_cnt <= '0;
    end else if (i_clear) begin
      acc_cnt <= '0;
    end else if (fire && (acc_cnt != WARM_LIMIT)) begin
      acc_cnt <= acc_cnt + ACC_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow valid pipe, aligned with the FIR pipeline stages
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      vld       <= '0;
      warm_pipe <= '0;
    end else if (i_clear) begin
      // Dropping the valid bits is what keeps stale FIR contents from ever
      // being captured after a clear.
      vld       <= '0;
      warm_pipe <= '0;
    end else begin
      vld[1]       <= fire;
      warm_pipe[1] <= (acc_cnt < WARM_LIMIT);
      for (int i = 2; i <= LATENCY; i++) begin
        vld[i]       <= vld[i-1];
        warm_pipe[i] <= warm_pipe[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO (show-ahead)
  // ---------------------------------------------------------------------------
  logic [WW_OUTPUT:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [WW_OUTPUT:0] head;

  assign o_m_valid = (fifo_count != '0);
  assign push      = vld[LATENCY] & ~i_clear;
  assign pop       = o_m_valid & i_m_ready & ~i_clear;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {warm_pipe[LATENCY], i_fir_data};
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (i_clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign head     = mem[rd_ptr];
  assign o_m_data = head[WW_OUTPUT-1:0];
  assign o_m_warm = head[WW_OUTPUT];
  assign o_busy   = (inflight != '0) | (fifo_count != '0);

  // The credit scheme must never let a capture land on a full FIFO.
  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (i_rst) !(push && (fifo_count == FULL_CNT))
  );

endmodule

// File: tb/tb_fir_stream_ctrl.sv
module tb_fir_stream_ctrl;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_s_valid;
  logic       o_s_ready;
  logic [7:0] i_s_data;
  logic       i_clear;
  logic       o_fir_en;
  logic       o_fir_srst;
  logic [7:0] o_fir_data;
  logic [7:0] i_fir_data;
  logic       o_m_valid;
  logic       i_m_ready;
  logic [7:0] o_m_data;
  logic       o_m_warm;
  logic       o_busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [8:0] exp_q[$];
  int         hist[$];

  always #5 clk = ~clk;

  fir_stream_ctrl dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_s_valid  (i_s_valid),
    .o_s_ready  (o_s_ready),
    .i_s_data   (i_s_data),
    .i_clear    (i_clear),
    .o_fir_en   (o_fir_en),
    .o_fir_srst (o_fir_srst),
    .o_fir_data (o_fir_data),
    .i_fir_data (i_fir_data),
    .o_m_valid  (o_m_valid),
    .i_m_ready  (i_m_ready),
    .o_m_data   (o_m_data),
    .o_m_warm   (o_m_warm),
    .o_busy     (o_busy)
  );

  // Behavioural filtro_fir: 15-tap line with coefficients 1..15, output
  // registered through three stages (valid 3 cycles after i_en).
  logic [7:0] sr    [15];
  logic [7:0] nsr   [15];
  int         fir_acc;
  logic [7:0] p1, p2, p3;

  always_comb begin
    for (int k = 0; k < 15; k++) nsr[k] = sr[k];
    if (o_fir_en) begin
      for (int k = 14; k > 0; k--) nsr[k] = sr[k-1];
      nsr[0] = o_fir_data;
    end
    if (o_fir_srst) begin
      for (int k = 0; k < 15; k++) nsr[k] = 8'h00;
    end
    fir_acc = 0;
    for (int k = 0; k < 15; k++) fir_acc = fir_acc + (k + 1) * int'(nsr[k]);
  end

  always @(posedge clk) begin
    for (int k = 0; k < 15; k++) sr[k] <= nsr[k];
    p1 <= fir_acc[7:0];
    p2 <= p1;
    p3 <= p2;
  end

  assign i_fir_data = p3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected word for a newly accepted sample, from the accepted history.
  task automatic accept(input logic [7:0] d);
    int acc;
    int n;
    logic warm;
    acc = 0;
    hist.push_back(int'(d));
    n = hist.size();
    for (int k = 0; k < 15; k++) begin
      if (k < n) acc = acc + (k + 1) * hist[n-1-k];
    end
    warm = (n <= 14);
    exp_q.push_back({warm, acc[7:0]});
  endtask

  task automatic flush();
    exp_q.delete();
    hist.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Output scoreboard: every pop must match the next expected word.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!i_rst && o_m_valid && i_m_ready && !i_clear) begin
      chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_word", 32'({o_m_warm, o_m_data}), 32'(e));
      end
    end
  end

  initial begin
    i_rst = 1'b1; i_s_valid = 1'b1; i_s_data = 8'h5A; i_clear = 1'b0; i_m_ready = 1'b0;

    // Reset
    repeat (3) step();
    samp();
    chk("rst_srst",   32'(o_fir_srst), 32'd1);
    chk("rst_ready",  32'(o_s_ready),  32'd0);
    chk("rst_mvalid", 32'(o_m_valid),  32'd0);
    chk("rst_busy",   32'(o_busy),     32'd0);
    chk("rst_en",     32'(o_fir_en),   32'd0);
    step(); i_rst = 1'b0; i_s_valid = 1'b0;
    samp();
    chk("rel_srst_hold",  32'(o_fir_srst), 32'd1);
    chk("rel_ready_hold", 32'(o_s_ready),  32'd0);
    step(); samp();
    chk("rel_srst_fall",  32'(o_fir_srst), 32'd0);
    chk("rel_ready_rise", 32'(o_s_ready),  32'd1);

    // Streaming, 20 samples back to back
    i_m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(); i_s_valid = 1'b1; i_s_data = 8'(i * 13 + 5);
      samp();
      chk("stream_ready", 32'(o_s_ready), 32'd1);
      chk("stream_en",    32'(o_fir_en),  32'd1);
      if (i == 0) chk("stream_fir_data", 32'(o_fir_data), 32'h05);
      if (i == 3) chk("first_valid_early", 32'(o_m_valid), 32'd0);
      if (i == 4) chk("first_valid",       32'(o_m_valid), 32'd1);
      accept(i_s_data);
    end
    step(); i_s_valid = 1'b0;
    drain("stream_drain");
    samp();
    chk("stream_idle", 32'(o_busy), 32'd0);

    // Backpressure: exactly FIFO_DEPTH samples accepted
    step(); i_m_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(); i_s_valid = 1'b1; i_s_data = 8'(8'hA0 + i);
      samp();
      chk("bp_ready", 32'(o_s_ready), 32'(i < 8));
      if (i < 8) accept(i_s_data);
    end
    step(); i_s_valid = 1'b0;
    samp();
    chk("bp_mvalid", 32'(o_m_valid), 32'd1);
    chk("bp_busy",   32'(o_busy),    32'd1);
    chk("bp_ready_hold", 32'(o_s_ready), 32'd0);
    step(); i_m_ready = 1'b1;
    drain("bp_drain");

    // Clear with 3 samples in flight and 2 buffered
    step(); i_m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); i_s_valid = 1'b1; i_s_data = 8'(8'h30 + i);
      samp();
      chk("clr_fill_ready", 32'(o_s_ready), 32'd1);
      accept(i_s_data);
    end
    step(); i_s_valid = 1'b0; i_clear = 1'b1; i_m_ready = 1'b1;
    samp();
    chk("clr_mvalid_before", 32'(o_m_valid), 32'd1);
    chk("clr_busy_before",   32'(o_busy),    32'd1);
    chk("clr_ready",         32'(o_s_ready), 32'd0);
    flush();
    step(); i_clear = 1'b0;
    samp();
    chk("clr_mvalid_after", 32'(o_m_valid),  32'd0);
    chk("clr_busy_after",   32'(o_busy),     32'd0);
    chk("clr_srst",         32'(o_fir_srst), 32'd1);
    chk("clr_ready_after",  32'(o_s_ready),  32'd0);
    step(); samp();
    chk("clr_srst_fall",  32'(o_fir_srst), 32'd0);
    chk("clr_ready_back", 32'(o_s_ready),  32'd1);
    step(); i_s_valid = 1'b1; i_s_data = 8'h55;
    samp();
    chk("clr_next_en", 32'(o_fir_en), 32'd1);
    accept(i_s_data);
    step(); i_s_valid = 1'b0;
    repeat (2) step();
    samp();
    chk("clr_next_early", 32'(o_m_valid), 32'd0);
    step(); samp();
    chk("clr_next_valid", 32'(o_m_valid), 32'd1);
    chk("clr_next_data",  32'(o_m_data),  32'h55);
    chk("clr_next_warm",  32'(o_m_warm),  32'd1);
    drain("clr_drain");

    // Clear and valid in the same cycle
    step(); i_s_valid = 1'b1; i_s_data = 8'hAA; i_clear = 1'b1;
    samp();
    chk("sim_ready", 32'(o_s_ready), 32'd0);
    chk("sim_en",    32'(o_fir_en),  32'd0);
    step(); i_s_valid = 1'b0; i_clear = 1'b0;
    flush();
    samp();
    chk("sim_srst", 32'(o_fir_srst), 32'd1);
    repeat (6) step();
    samp();
    chk("sim_mvalid", 32'(o_m_valid), 32'd0);
    chk("sim_busy",   32'(o_busy),    32'd0);

    // Asynchronous reset while busy
    i_m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); i_s_valid = 1'b1; i_s_data = 8'(8'h11 * (i + 1));
      samp();
      chk("ar_fill_ready", 32'(o_s_ready), 32'd1);
      accept(i_s_data);
    end
    chk("ar_mvalid_pre", 32'(o_m_valid), 32'd1);
    step();
    #2; i_rst = 1'b1;
    #1;
    chk("ar_srst",   32'(o_fir_srst), 32'd1);
    chk("ar_ready",  32'(o_s_ready),  32'd0);
    chk("ar_en",     32'(o_fir_en),   32'd0);
    chk("ar_mvalid", 32'(o_m_valid),  32'd0);
    chk("ar_busy",   32'(o_busy),     32'd0);
    flush();
    i_s_valid = 1'b0;
    repeat (2) step();
    i_rst = 1'b0;
    samp();
    chk("ar_rel_srst",  32'(o_fir_srst), 32'd1);
    chk("ar_rel_ready", 32'(o_s_ready),  32'd0);
    step(); samp();
    chk("ar_srst_fall", 32'(o_fir_srst), 32'd0);
    chk("ar_ready_rise", 32'(o_s_ready), 32'd1);
    step(); i_m_ready = 1'b1; i_s_valid = 1'b1; i_s_data = 8'h09;
    samp();
    chk("ar_next_en", 32'(o_fir_en), 32'd1);
    accept(i_s_data);
    step(); i_s_valid = 1'b0;
    repeat (2) step();
    samp();
    chk("ar_next_early", 32'(o_m_valid), 32'd0);
    step(); samp();
    chk("ar_next_valid", 32'(o_m_valid), 32'd1);
    chk("ar_next_data",  32'(o_m_data),  32'h09);
    chk("ar_next_warm",  32'(o_m_warm),  32'd1);
    drain("ar_drain");
    samp();
    chk("final_busy", 32'(o_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fir_stream_ctrl.md
# fir_stream_ctrl

Stream controller that sequences `filtro_fir`, which has no flow control. It turns a valid/ready input stream into `i_en` pulses and tracks each accepted sample through the fixed FIR pipeline latency. The result is captured into an output FIFO and presented as a valid/ready stream carrying a warm-up flag. Credit-based admission means downstream backpressure never loses a sample. The block also drives the FIR `i_srst` on reset release and on a clear command.

## Interface
- `WW_INPUT`, 8, sample width into the FIR.
- `WW_OUTPUT`, 8, FIR output width.
- `LATENCY`, 3, cycles from FIR `i_en` high until `o_data` is valid (prod_d, sum_d, sum3_d stages).
- `NUM_TAPS`, 15, FIR tap count; the warm-up window is `NUM_TAPS-1` outputs.
- `FIFO_DEPTH`, 8, output FIFO entries. Must be a power of 2 and at least `LATENCY+2` for full throughput.

- `clk` input 1: single clock, rising edge.
- `i_rst` input 1: reset, asynchronous, active-high.
- `i_s_valid` input 1: input sample valid.
- `o_s_ready` output 1: controller accepts the sample this cycle.
- `i_s_data` input `WW_INPUT`: input sample.
- `i_clear` input 1: synchronous clear command (single-cycle or level).
- `o_fir_en` output 1: drives FIR `i_en`.
- `o_fir_srst` output 1: drives FIR `i_srst`.
- `o_fir_data` output `WW_INPUT`: drives FIR `i_data`.
- `i_fir_data` input `WW_OUTPUT`: FIR `o_data`.
- `o_m_valid` output 1: output sample valid.
- `i_m_ready` input 1: downstream ready.
- `o_m_data` output `WW_OUTPUT`: filtered sample.
- `o_m_warm` output 1: the sample was produced before `NUM_TAPS-1` inputs had been accepted since the last reset or clear.
- `o_busy` output 1: a sample is in flight or the FIFO is non-empty.

## Operation
- Handshake: `fire = i_s_valid & o_s_ready`.
  - `o_fir_en = fire`.
  - `o_fir_data = i_s_data` (combinational passthrough).
- Admission: `o_s_ready = ~i_clear & ~srst_q & (fifo_count + inflight < FIFO_DEPTH)`.
  - `inflight` is the number of set bits in the valid pipe.
- Valid pipe: `vld[1..LATENCY]` plus a warm bit per stage.
  - `vld[1] <= fire`, `warm[1] <= (acc_cnt < NUM_TAPS-1)`, then each stage shifts by one.
- Capture: when `vld[LATENCY]` is 1, push `{warm[LATENCY], i_fir_data}` into the FIFO at the next edge.
- `acc_cnt`: counts fires, saturating at `NUM_TAPS-1`. It resets to 0 on `i_rst` or a clear.
- FIFO: show-ahead.
  - `o_m_valid = (fifo_count != 0)`; `o_m_data` and `o_m_warm` come from the read pointer.
  - Pop on `o_m_valid & i_m_ready`.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers are log2(`FIFO_DEPTH`) bits and wrap naturally.
  - Credit admission guarantees a push never occurs while the FIFO is full. An assertion checks this.
- Clear: `i_clear` sampled high at an edge causes all of the following at that edge:
  - `srst_q <= 1`;
  - all `vld` bits cleared;
  - FIFO pointers and count zeroed;
  - `acc_cnt <= 0`.
- `o_fir_srst = srst_q`. It stays high for one cycle after the last cycle `i_clear` is high.
- In-flight FIR pipeline contents after a clear are never captured, because their valid bits were dropped.
- `o_busy = (inflight != 0) | (fifo_count != 0)`.

## Timing
- Reset values:
  - `srst_q = 1`, so `o_fir_srst = 1` and `o_s_ready = 0`;
  - `o_m_valid = 0`, `o_busy = 0`, `o_fir_en = 0`;
  - `vld`, `acc_cnt` and FIFO state all 0.
- The first edge after `i_rst` falls clears `srst_q`, and the FIR shift register is zeroed at that same edge. `o_s_ready` can first be high in the following cycle.
- Latency: fire in cycle t, `vld[LATENCY]` high in cycle t+LATENCY, push at the end of that cycle, and `o_m_valid` high in cycle t+LATENCY+1 (t+4 with defaults).
- Throughput: 1 sample/cycle sustained when `i_m_ready=1` and `FIFO_DEPTH >= LATENCY+2`.
- `i_clear` and `i_s_valid` in the same cycle: the sample is not accepted.
- `i_clear` while `i_m_ready` pops: the pop is discarded and the FIFO is emptied.
- Asserting `i_rst` mid-operation clears all state immediately. No output is produced for samples in flight.

## Test plan
- Reset: hold `i_rst`.
  - During reset: `o_fir_srst=1`, `o_s_ready=0`, `o_m_valid=0`, `o_busy=0`.
  - After release: `o_fir_srst` falls after 1 edge and `o_s_ready` rises in the next cycle.
- Streaming: 20 back-to-back samples with `i_m_ready=1`.
  - `o_s_ready` stays 1 throughout.
  - First `o_m_valid` appears 4 cycles after the first fire.
  - 20 outputs in order: the first 14 have `o_m_warm=1` and the last 6 have `o_m_warm=0`.
  - Data matches a golden FIR model.
- Backpressure: `i_m_ready=0` with a continuous `i_s_valid`.
  - Exactly 8 samples are accepted, then `o_s_ready=0`.
  - After `i_m_ready=1`, 8 correct outputs drain in order with no loss or duplication.
- Clear mid-stream: pulse `i_clear` with 3 samples in flight and 2 in the FIFO.
  - `o_m_valid=0` the next cycle, `o_fir_srst` high for 1 cycle, and none of the 5 samples emerges.
  - The next accepted sample emerges with `o_m_warm=1` and FIR history zeroed.
- Simultaneous clear and valid: `i_clear=1` with `i_s_valid=1`.
  - `o_s_ready=0` and `o_fir_en=0`, so that sample is never output.
- Async reset mid-operation: assert `i_rst` between clock edges while busy.
  - Outputs take their reset values immediately, without waiting for a clock edge.
  - After release, the operation matches a fresh start.
